// File: rtl/eth_rx_mii_gen_pkg.sv
// Shared constants, state encoding and CRC helpers for the Ethernet receive front end.
package eth_rx_mii_gen_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;

    // Bit positions inside rx_err_code
    localparam int ERR_CRC   = 0;
    localparam int ERR_PHY   = 1;
    localparam int ERR_LEN   = 2;
    localparam int ERR_ALIGN = 3;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } rx_state_e;

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    // One byte of reflected CRC32, LSB of the data byte first
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic [7:0]  dd;
        r  = c;
        dd = d;
        for (int unsigned i = 0; i < 8; i++) begin
            r  = (r[0] ^ dd[0]) ? ((r >> 1) ^ CRC_POLY_REFL) : (r >> 1);
            dd = dd >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_rx_mii_gen_crc32.sv
// Byte-wide CRC32 accumulator: reflected 0x04C11DB7, all-ones init, inverted output.
module eth_rx_mii_gen_crc32
    import eth_rx_mii_gen_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        vld_i,
    input  logic [7:0]  dat_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q, crc_d;

    // Fold in one byte whenever vld_i is high
    always_comb begin
        crc_d = crc_q;
        if (vld_i) crc_d = crc32_byte(crc_q, dat_i);
    end

    // CRC state register, re-seeded on rst_i
    always_ff @(posedge clk_i) begin
        if (rst_i) crc_q <= '1;
        else       crc_q <= crc_d;
    end

    assign crc_o = ~crc_q;

endmodule

// File: rtl/eth_rx_mii_gen.sv
// Ethernet receive front end for RMII/MII/GMII symbol streams: preamble hunt, byte
// assembly, optional FCS strip, CRC check and frame fault classification.
module eth_rx_mii_gen
    import eth_rx_mii_gen_pkg::*;
#(
    parameter int PHY_W     = 2,
    parameter int PRE_MIN   = 7,
    parameter int MIN_LEN   = 64,
    parameter int MAX_LEN   = 1518,
    parameter int STRIP_FCS = 1,
    parameter int LEN_W     = 11
)(
    input  logic             clk_mac,
    input  logic             rst,
    input  logic             eth_crsdv,
    input  logic             eth_rxerr,
    input  logic [PHY_W-1:0] eth_rxd,
    output logic             rx_vld,
    output logic [7:0]       rx_dat,
    output logic             rx_sof,
    output logic             rx_eof,
    output logic [LEN_W-1:0] rx_len,
    output logic             rx_err,
    output logic [3:0]       rx_err_code
);

    localparam int             SPB      = 8 / PHY_W;
    localparam int             HW       = 8 * (PRE_MIN + 1);
    localparam logic [HW-1:0]  SYNC_PAT = {SFD_BYTE, {PRE_MIN{PREAMBLE_BYTE}}};
    localparam logic [2:0]     SYM_LAST = 3'(SPB - 1);

    logic             crsdv_b_q, rxerr_b_q;
    logic [PHY_W-1:0] rxd_b_q;

    rx_state_e        state_q, state_d;
    logic [HW-1:0]    hist_q, hist_d;
    logic [2:0]       sym_q, sym_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc, len_q, len_d;
    logic             ovf_q, ovf_d, first_q, first_d;
    logic [31:0]      dl_q, dl_d;
    logic [7:0]       byte_new, out_byte;
    logic             sfd_det, sym_adv, byte_done, end_frm, err_frm, eof, dlv;
    logic [31:0]      crc_val;
    logic [3:0]       code_c;

    logic             rx_vld_q, rx_vld_d, rx_sof_q, rx_sof_d, rx_eof_q, rx_eof_d, rx_err_q, rx_err_d;
    logic [7:0]       rx_dat_q, rx_dat_d;
    logic [LEN_W-1:0] rx_len_q, rx_len_d;
    logic [3:0]       code_q, code_d;

    // Single input register stage; free-running so reset can see live carrier
    always_ff @(posedge clk_mac) begin
        crsdv_b_q <= eth_crsdv;
        rxerr_b_q <= eth_rxerr;
        rxd_b_q   <= eth_rxd;
    end

    // Frame event decode
    assign sym_adv   = (state_q == RECV) && crsdv_b_q && !rxerr_b_q;
    assign byte_done = sym_adv && (sym_q == SYM_LAST);
    assign end_frm   = (state_q == RECV) && !crsdv_b_q;
    assign err_frm   = (state_q == RECV) && crsdv_b_q && rxerr_b_q;
    assign eof       = end_frm || err_frm;
    assign sfd_det   = (state_q == HUNT) && (hist_d == SYNC_PAT);
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign dlv       = byte_done && (cnt_inc <= LEN_W'(MAX_LEN)) &&
                       ((STRIP_FCS == 0) || (cnt_q >= LEN_W'(4)));
    assign out_byte  = (STRIP_FCS != 0) ? dl_q[7:0] : byte_new;

    // Symbol-to-byte shifter: pending symbols sit LSB-aligned, newest symbol completes the byte
    if (PHY_W == 8) begin : g_byte
        assign byte_new = rxd_b_q;
    end else begin : g_shift
        logic [7-PHY_W:0] pend_q;
        assign byte_new = {rxd_b_q, pend_q};
        // Keep the most recent symbols of the byte under assembly
        always_ff @(posedge clk_mac) begin
            if (rst)          pend_q <= '0;
            else if (sym_adv) pend_q <= byte_new[7:PHY_W];
        end
    end

    // CRC is fed from the tail of the 4-byte delay line, so at frame end it covers
    // exactly DA..payload and the line itself holds the received FCS.
    eth_rx_mii_gen_crc32 u_crc (
        .clk_i (clk_mac),
        .rst_i (rst || sfd_det),
        .vld_i (byte_done && (cnt_q >= LEN_W'(4))),
        .dat_i (dl_q[7:0]),
        .crc_o (crc_val)
    );

    // State register; carrier present at reset release means we joined mid-frame
    always_ff @(posedge clk_mac) begin
        if (rst) state_q <= eth_crsdv ? DROP : HUNT;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HUNT:    if (sfd_det) state_d = RECV;
            RECV:    if (end_frm) state_d = HUNT;
                     else if (err_frm) state_d = DROP;
            DROP:    if (!crsdv_b_q) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    // Datapath next-state: preamble history, counters and delay line
    always_comb begin
        hist_d  = '0;
        if ((state_q == HUNT) && crsdv_b_q && !rxerr_b_q)
            hist_d = {rxd_b_q, hist_q[HW-1:PHY_W]};
        sym_d   = sym_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        first_d = first_q;
        dl_d    = dl_q;
        if (sfd_det) begin
            sym_d   = '0;
            cnt_d   = '0;
            len_d   = '0;
            ovf_d   = 1'b0;
            first_d = 1'b1;
        end else begin
            if (sym_adv) sym_d = byte_done ? 3'd0 : sym_q + 3'd1;
            if (byte_done) begin
                cnt_d = cnt_inc;
                dl_d  = {byte_new, dl_q[31:8]};
                if (cnt_inc > LEN_W'(MAX_LEN)) ovf_d = 1'b1;
            end
            if (dlv) len_d = len_q + 1'b1;
            if (dlv || eof) first_d = 1'b0;
        end
    end

    // Output decode: data beat on delivery, EOF beat with status on frame end
    always_comb begin
        code_c            = '0;
        code_c[ERR_CRC]   = (dl_q != crc_val);
        code_c[ERR_PHY]   = err_frm;
        code_c[ERR_LEN]   = ovf_q || (cnt_q < LEN_W'(MIN_LEN)) || first_q;
        code_c[ERR_ALIGN] = (sym_q != 3'd0);
        rx_vld_d = dlv || eof;
        rx_dat_d = dlv ? out_byte : 8'h00;
        rx_sof_d = (dlv || eof) && first_q;
        rx_eof_d = eof;
        rx_len_d = eof ? len_q : '0;
        code_d   = eof ? code_c : '0;
        rx_err_d = eof && (|code_c);
    end

    // Datapath and output registers
    always_ff @(posedge clk_mac) begin
        if (rst) begin
            hist_q   <= '0;
            sym_q    <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            ovf_q    <= 1'b0;
            first_q  <= 1'b0;
            dl_q     <= '0;
            rx_vld_q <= 1'b0;
            rx_dat_q <= '0;
            rx_sof_q <= 1'b0;
            rx_eof_q <= 1'b0;
            rx_len_q <= '0;
            rx_err_q <= 1'b0;
            code_q   <= '0;
        end else begin
            hist_q   <= hist_d;
            sym_q    <= sym_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            ovf_q    <= ovf_d;
            first_q  <= first_d;
            dl_q     <= dl_d;
            rx_vld_q <= rx_vld_d;
            rx_dat_q <= rx_dat_d;
            rx_sof_q <= rx_sof_d;
            rx_eof_q <= rx_eof_d;
            rx_len_q <= rx_len_d;
            rx_err_q <= rx_err_d;
            code_q   <= code_d;
        end
    end

    assign rx_vld      = rx_vld_q;
    assign rx_dat      = rx_dat_q;
    assign rx_sof      = rx_sof_q;
    assign rx_eof      = rx_eof_q;
    assign rx_len      = rx_len_q;
    assign rx_err      = rx_err_q;
    assign rx_err_code = code_q;

endmodule

// File: tb/tb_eth_rx_mii_gen.sv
// Directed bench: three receivers (PHY_W 2/4/8) on one clock, frames built with a
// reference CRC, output stream scored by a monitor against the transmitted bytes.
module tb_eth_rx_mii_gen;

    localparam int FRM_MAX = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  crsdv = '0;
    logic [2:0]  rxerr = '0;
    logic [1:0]  rxd2 = '0;
    logic [3:0]  rxd4 = '0;
    logic [7:0]  rxd8 = '0;

    logic [2:0]  vld, sof, eofo, errb;
    logic [7:0]  dat  [3];
    logic [10:0] len  [3];
    logic [3:0]  code [3];

    logic [7:0]  frm [0:FRM_MAX-1];

    int n_chk = 0;
    int n_err = 0;

    int beats [3]  = '{0, 0, 0};
    int eofs  [3]  = '{0, 0, 0};
    int idx   [3]  = '{0, 0, 0};
    int dbad  [3]  = '{0, 0, 0};
    int sbad  [3]  = '{0, 0, 0};
    int l_len [3]  = '{0, 0, 0};
    int l_code[3]  = '{0, 0, 0};
    int l_err [3]  = '{0, 0, 0};
    int l_sof [3]  = '{0, 0, 0};

    always #5 clk = ~clk;

    eth_rx_mii_gen #(.PHY_W(2)) u2 (
        .clk_mac(clk), .rst(rst), .eth_crsdv(crsdv[0]), .eth_rxerr(rxerr[0]), .eth_rxd(rxd2),
        .rx_vld(vld[0]), .rx_dat(dat[0]), .rx_sof(sof[0]), .rx_eof(eofo[0]),
        .rx_len(len[0]), .rx_err(errb[0]), .rx_err_code(code[0]));

    eth_rx_mii_gen #(.PHY_W(4)) u4 (
        .clk_mac(clk), .rst(rst), .eth_crsdv(crsdv[1]), .eth_rxerr(rxerr[1]), .eth_rxd(rxd4),
        .rx_vld(vld[1]), .rx_dat(dat[1]), .rx_sof(sof[1]), .rx_eof(eofo[1]),
        .rx_len(len[1]), .rx_err(errb[1]), .rx_err_code(code[1]));

    eth_rx_mii_gen #(.PHY_W(8)) u8 (
        .clk_mac(clk), .rst(rst), .eth_crsdv(crsdv[2]), .eth_rxerr(rxerr[2]), .eth_rxd(rxd8),
        .rx_vld(vld[2]), .rx_dat(dat[2]), .rx_sof(sof[2]), .rx_eof(eofo[2]),
        .rx_len(len[2]), .rx_err(errb[2]), .rx_err_code(code[2]));

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                idx[i] = 0;
            end else if (vld[i]) begin
                if (eofo[i]) begin
                    eofs[i]++;
                    l_len[i]  = int'(len[i]);
                    l_code[i] = int'(code[i]);
                    l_err[i]  = int'(errb[i]);
                    l_sof[i]  = int'(sof[i]);
                    idx[i]    = 0;
                end else begin
                    beats[i]++;
                    if (sof[i] != (idx[i] == 0)) sbad[i]++;
                    if (idx[i] < FRM_MAX && dat[i] != frm[idx[i]]) dbad[i]++;
                    idx[i]++;
                end
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_crc(input int n);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            b = frm[i];
            for (int k = 0; k < 8; k++) begin
                if (c[0] ^ b[k]) c = (c >> 1) ^ 32'hEDB88320;
                else             c = c >> 1;
            end
        end
        return ~c;
    endfunction

    // Fill n bytes with a pattern, optionally append the 4 FCS bytes (CRC[7:0] first)
    task automatic build_frame(input int n, input int add_fcs, input int seed);
        logic [31:0] fcs;
        for (int i = 0; i < n; i++) frm[i] = 8'((i * 37 + seed * 11 + 5) ^ (i >> 3));
        if (add_fcs != 0) begin
            fcs = ref_crc(n);
            for (int j = 0; j < 4; j++) frm[n + j] = fcs[8*j +: 8];
        end
    endtask

    task automatic drive_sym(input int sel, input logic [7:0] sym, input logic crs, input logic err);
        @(posedge clk);
        #1;
        rxd2  = sym[1:0];
        rxd4  = sym[3:0];
        rxd8  = sym;
        crsdv = '0;
        rxerr = '0;
        crsdv[sel] = crs;
        rxerr[sel] = err;
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b, input logic err);
        int w;
        w = 2 << sel;
        for (int k = 0; k < 8 / w; k++)
            drive_sym(sel, 8'(b >> (k * w)), 1'b1, err && (k == 0));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive_sym(0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_pre(input int sel);
        for (int p = 0; p < 7; p++) send_byte(sel, 8'h55, 1'b0);
        send_byte(sel, 8'hD5, 1'b0);
    endtask

    task automatic send_frame(input int sel, input int total, input int extra, input int err_at);
        send_pre(sel);
        for (int i = 0; i < total; i++) send_byte(sel, frm[i], i == err_at);
        for (int e = 0; e < extra; e++) drive_sym(sel, 8'h00, 1'b1, 1'b0);
        idle(15);
    endtask

    task automatic run_frame(input string name, input int sel, input int total, input int extra,
                             input int err_at, input int exp_beats, input int exp_len,
                             input int exp_code, input int mask);
        int b0, e0, d0, s0;
        b0 = beats[sel]; e0 = eofs[sel]; d0 = dbad[sel]; s0 = sbad[sel];
        send_frame(sel, total, extra, err_at);
        check({name, "_eofs"},  eofs[sel] - e0, 1);
        check({name, "_beats"}, beats[sel] - b0, exp_beats);
        check({name, "_len"},   l_len[sel], exp_len);
        check({name, "_code"},  l_code[sel] & mask, exp_code);
        check({name, "_err"},   l_err[sel], (exp_code != 0) ? 1 : 0);
        check({name, "_eofsof"}, l_sof[sel], (exp_beats == 0) ? 1 : 0);
        check({name, "_data"},  dbad[sel] - d0, 0);
        check({name, "_sof"},   sbad[sel] - s0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, e0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_outputs", int'({vld, sof, eofo, errb}) + int'(len[0]) + int'(len[1]) +
              int'(len[2]) + int'(code[0]) + int'(code[1]) + int'(code[2]), 0);
        rst = 1'b0;
        idle(5);

        // RMII good frame: 60 bytes + FCS
        build_frame(60, 1, 1);
        run_frame("t1_good", 0, 64, 0, -1, 60, 60, 4'b0000, 4'hF);

        // Same frame, one payload bit flipped
        frm[10] = frm[10] ^ 8'h04;
        run_frame("t2_crc", 0, 64, 0, -1, 60, 60, 4'b0001, 4'hF);

        // MII, PHY error at byte 20: 16 bytes out of the delay line, then drop
        build_frame(60, 1, 2);
        run_frame("t3_rxerr", 1, 64, 0, 20, 16, 16, 4'b0010, 4'b0010);
        run_frame("t3_after", 1, 64, 0, -1, 60, 60, 4'b0000, 4'hF);

        // GMII oversize 2000-byte frame, then back-to-back good frame
        build_frame(1996, 1, 3);
        run_frame("t4_over", 2, 2000, 0, -1, 1514, 1514, 4'b0100, 4'hF);
        build_frame(60, 1, 4);
        run_frame("t4_next", 2, 64, 0, -1, 60, 60, 4'b0000, 4'hF);

        // RMII good 64-byte frame plus one stray dibit
        build_frame(60, 1, 5);
        run_frame("t5_align", 0, 64, 1, -1, 60, 60, 4'b1000, 4'hF);

        // Three-byte frame: nothing survives the FCS hold, single SOF+EOF beat
        build_frame(3, 0, 6);
        run_frame("t7_tiny", 0, 3, 0, -1, 0, 0, 4'b0100, 4'b0100);

        // Reset mid-frame with carrier held high on the MII instance
        build_frame(60, 1, 7);
        send_pre(1);
        for (int i = 0; i < 30; i++) send_byte(1, frm[i], 1'b0);
        rst = 1'b1;
        send_byte(1, frm[30], 1'b0);
        check("t6_rst_out", int'({vld[1], sof[1], eofo[1]}), 0);
        send_byte(1, frm[31], 1'b0);
        rst = 1'b0;
        b0 = beats[1];
        e0 = eofs[1];
        for (int i = 32; i < 64; i++) send_byte(1, frm[i], 1'b0);
        idle(15);
        check("t6_no_eof", eofs[1] - e0, 0);
        check("t6_no_beats", beats[1] - b0, 0);
        build_frame(60, 1, 8);
        run_frame("t6_next", 1, 64, 0, -1, 60, 60, 4'b0000, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
